alu_serial_sequencer: RTL and testbench
=======================================

Name: alu_serial_sequencer

Overview:
Multi-cycle wrapper that runs word-wide operations (default 16 bit) through one ALU4Bit slice, one nibble per clock. It sits directly upstream of ALU4Bit and also consumes its outputs. It latches operands, drives the slice nibble by nibble, chains carry between nibbles, and assembles result and flags. It trades latency for area in the datapath.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per word; word width W = 4*NIBBLES; must be >= 1.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when ready=1
a  input  W  operand A; sampled together with start
b  input  W  operand B; sampled together with start
op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
ready  output  1  1 in IDLE and DONE (new start accepted)
done  output  1  one-cycle pulse when result/flags become valid
result  output  W  assembled result; held until next accepted start
cout  output  1  final carry for ADD/SUB; 0 for all other ops
zero  output  1  1 iff the final result (after SLT fix-up) == 0
set  output  1  MSB of the raw final nibble result (sign of the difference for SUB/SLT)

Behaviour:
- Reset values: ready=1, done=0, result=0, cout=0, zero=0, set=0. State is IDLE and nibble index is 0.
- FSM states are IDLE, RUN and DONE.
- IDLE/DONE with start=1 at edge k:
  - latch a, b and the effective op;
  - idx<=0, zero accumulator<=1, go RUN.
  - DONE without start returns to IDLE with outputs held.
- Effective op:
  - SLT drives the slice with 110 (subtract).
  - Undefined codes (011, 100, 101) execute as AND (000), with the same latency.
- RUN, nibble idx:
  - Slice a/b = latched nibble idx.
  - cin = op[2] when idx==0 (1 for SUB/SLT), else carry_q.
  - less is tied to 0.
  - Edge captures the slice result into result_q[4*idx+3:4*idx] and slice cout into carry_q.
  - The zero accumulator is ANDed with (slice result==0).
- The edge at idx==NIBBLES-1 also:
  - captures slice set;
  - applies fix-up (SLT: result = {W-1 zeros, set});
  - drives outputs;
  - goes DONE.
- Latency: start at edge k -> RUN edges k+1..k+NIBBLES; done=1 for exactly the cycle after edge k+NIBBLES (NIBBLES+1 cycles start-to-done).
- ready=0 throughout RUN. start during RUN is ignored with no queuing, and latched operands are unaffected.
- Outputs result/cout/zero/set update only at completion. During RUN they keep the previous operation's values.
- Back-to-back: start in the DONE cycle is accepted, so done pulses every NIBBLES+1 cycles.
- Zero for SLT is computed on the fixed-up result, not the difference.
- Overflow is not detected. set is the raw MSB and is not overflow-corrected; SLT inherits this.
- rst mid-RUN: next cycle is IDLE with all outputs at reset values, and done is not pulsed for the aborted op.
- rst takes priority over start in the same cycle.

Decomposition:
- Shared package alu_pkg:
  - op-code constants OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT;
  - FSM state encoding (IDLE, RUN, DONE).
- One sub-module: an instance of the existing ALU4Bit slice.
- Nibble mux, carry register, result assembly and FSM live in alu_serial_sequencer itself.

Test Plan:
- ADD a=0x00FF b=0x0001 -> result 0x0100, cout 0, zero 0, done exactly 5 cycles after the start edge, ready low for 4 cycles.
- ADD 0xFFFF+0x0001 -> result 0x0000, cout 1, zero 1; SUB 0x1234-0x1234 -> result 0x0000, cout 1, zero 1, set 0.
- SLT a=0x0003 b=0x0005 -> result 0x0001, zero 0, set 1; SLT a=0x0005 b=0x0003 -> result 0x0000, zero 1, set 0.
- AND 0xF0F0,0x3C3C -> 0x3030, then start with OR 0x0F00,0x00F0 in the DONE cycle -> 0x0FF0 after 5 more cycles. A start pulse with op=101 mid-RUN is ignored.
- Undefined op 100 with a=0xFFFF b=0x00FF -> 0x00FF (executed as AND), cout 0, same 5-cycle latency.
- ADD started, rst asserted on the 2nd RUN cycle -> next cycle ready=1, result=0, flags 0, no done pulse; a following ADD 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU sequencer.
// It holds the op-code constants, the FSM state encoding and the op remapping
// that turns a user op into the op driven onto the 4-bit slice.
package alu_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned OP_W  = 3;

    localparam logic [OP_W-1:0] OP_AND = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [OP_W-1:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // SLT runs as a subtraction, and its result is fixed up at the end.
    // Undefined codes fall back to AND.
    function automatic logic [OP_W-1:0] eff_op(input logic [OP_W-1:0] op);
        logic [OP_W-1:0] r;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: r = op;
            OP_SLT:                        r = OP_SUB;
            default:                       r = OP_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ALU4Bit.sv
// 4-bit ALU slice. This is combinational and is meant to be chained through cin/cout.
// Ports: a, b    - nibble operands
//        cin     - carry in
//        less    - value returned for op[1:0]==11 (slt chaining)
//        op      - op[2] inverts b; op[1:0]: 00 AND, 01 OR, 10 sum, 11 less
//        result  - nibble result
//        cout    - adder carry out
//        set     - sign of the raw result (adder MSB when op[1:0]==11)
module ALU4Bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       cout,
    output logic       set
);

    logic [3:0] b_eff;
    logic [4:0] sum;
    logic [3:0] res_c;

    // Adder, with optional inversion of b for subtract.
    always_comb begin
        b_eff = op[2] ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
        case (op[1:0])
            2'b00:   res_c = a & b;
            2'b01:   res_c = a | b;
            2'b10:   res_c = sum[3:0];
            default: res_c = {3'b000, less};
        endcase
        result = res_c;
        cout   = sum[4];
        set    = (op[1:0] == 2'b11) ? sum[3] : res_c[3];
    end

endmodule

// File: rtl/alu_serial_sequencer.sv
// Multi-cycle wrapper that runs a W-bit operation through one ALU4Bit slice,
// one nibble per clock, LSB nibble first, with the carry chained through a register.
// Ports: clk, rst (sync, active high)
//        start, a, b, op - request, sampled only while ready=1
//        ready           - high in IDLE/DONE
//        done            - one-cycle pulse when result/flags update
//        result, cout, zero, set - held until the next completion
module alu_serial_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic [2:0]             op,
    output logic                   ready,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   zero,
    output logic                   set
);

    localparam int unsigned W  = NIB_W * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            slt_q, slt_d;
    logic            arith_q, arith_d;
    logic            carry_q, carry_d;
    logic            zacc_q, zacc_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            zero_q, zero_d;
    logic            set_q, set_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;

    logic [3:0]      slice_a, slice_b, slice_res;
    logic            slice_cin, slice_cout, slice_set;

    // Nibble mux and carry-in selection for the slice.
    always_comb begin
        slice_a   = 4'(a_q >> {idx_q, 2'b00});
        slice_b   = 4'(b_q >> {idx_q, 2'b00});
        slice_cin = (idx_q == '0) ? op_q[2] : carry_q;
    end

    ALU4Bit u_slice (
        .a      (slice_a),
        .b      (slice_b),
        .cin    (slice_cin),
        .less   (1'b0),
        .op     (op_q),
        .result (slice_res),
        .cout   (slice_cout),
        .set    (slice_set)
    );

    // Next-state logic: the FSM, result assembly and flag generation.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        slt_d    = slt_q;
        arith_d  = arith_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        set_d    = set_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = eff_op(op);
                    slt_d   = (op == OP_SLT);
                    arith_d = (op == OP_ADD) || (op == OP_SUB);
                    idx_d   = '0;
                    zacc_d  = 1'b1;
                    carry_d = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) acc_d[4*i +: 4] = slice_res;
                end
                carry_d = slice_cout;
                zacc_d  = zacc_q & (slice_res == 4'h0);
                if (idx_q == IW'(NIBBLES - 1)) begin
                    // The last nibble publishes everything. The SLT result collapses to its sign bit.
                    result_d = slt_q ? W'(slice_set) : acc_d;
                    cout_d   = arith_q & slice_cout;
                    zero_d   = slt_q ? ~slice_set : zacc_d;
                    set_d    = slice_set;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != RUN);
    end

    // State register. Reset is synchronous and wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            slt_q    <= 1'b0;
            arith_q  <= 1'b0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            set_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            slt_q    <= slt_d;
            arith_q  <= arith_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            set_q    <= set_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
    assign set    = set_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer. The DUT is compared against a
// word-level arithmetic model.
module tb_alu_serial_sequencer;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         ready, done, cout, zero, set;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_serial_sequencer #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .op     (op),
        .ready  (ready),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .set    (set)
    );

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         s;
    } exp_t;

    // Word-level reference model.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [W:0] t;
        e = '0;
        case (o)
            3'b001: e.r = x | y;
            3'b010: begin
                t = {1'b0, x} + {1'b0, y};
                e.r = t[W-1:0];
                e.c = t[W];
            end
            3'b110: begin
                t = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                e.r = t[W-1:0];
                e.c = t[W];
            end
            3'b111: begin
                t = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
                e.s = t[W-1];
                e.r = W'(t[W-1]);
            end
            default: e.r = x & y;
        endcase
        if (o != 3'b111) e.s = e.r[W-1];
        e.z = (e.r == '0);
        return e;
    endfunction

    // Issue one op and wait for done. Returns the latency in edges after the start
    // edge, the number of not-ready samples, and whether the outputs moved before done.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke, output int lat, output int rdy_low,
                          output bit changed, output bit timeout);
        logic [W-1:0] r0;
        logic c0, z0, s0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        r0 = result; c0 = cout; z0 = zero; s0 = set;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
        lat = 0; rdy_low = 0; changed = 1'b0; timeout = 1'b0;
        while (done !== 1'b1) begin
            if (ready === 1'b0) rdy_low++;
            if (result !== r0 || cout !== c0 || zero !== z0 || set !== s0) changed = 1'b1;
            if (lat >= 4 * NIB + 4) begin
                timeout = 1'b1;
                break;
            end
            if (poke && lat == 1) begin
                start = 1'b1; op = 3'b101;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({ready, done} !== 2'b10) begin
            fails++;
            $display("FAIL reset_ctrl: ready/done=%b required 10", {ready, done});
        end
        tests++;
        if ({result, cout, zero, set} !== {W'(0), 3'b000}) begin
            fails++;
            $display("FAIL reset_outputs: result=%h c/z/s=%b%b%b required 0000 000", result, cout, zero, set);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [2:0]   ops [6] = '{3'b010, 3'b010, 3'b110, 3'b111, 3'b111, 3'b100};
        logic [W-1:0] as  [6] = '{16'h00FF, 16'hFFFF, 16'h1234, 16'h0003, 16'h0005, 16'hFFFF};
        logic [W-1:0] bs  [6] = '{16'h0001, 16'h0001, 16'h1234, 16'h0005, 16'h0003, 16'h00FF};
        logic [W-1:0] rs  [6] = '{16'h0100, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h00FF};
        logic [2:0]   czs [6] = '{3'b000, 3'b110, 3'b110, 3'b001, 3'b010, 3'b000};
        int lat, rl;
        bit ch, to;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b0, lat, rl, ch, to);
            e = model(ops[i], as[i], bs[i]);
            tests++;
            if (to || lat != NIB || rl != NIB) begin
                fails++;
                $display("FAIL dir%0d_timing: latency=%0d ready_low=%0d timeout=%0b required %0d/%0d/0", i, lat, rl, to, NIB, NIB);
            end
            tests++;
            if ({result, cout, zero, set} !== {rs[i], czs[i]}) begin
                fails++;
                $display("FAIL dir%0d_value: result=%h c/z/s=%b%b%b required %h %b", i, result, cout, zero, set, rs[i], czs[i]);
            end
            tests++;
            if ({result, cout, zero, set} !== e) begin
                fails++;
                $display("FAIL dir%0d_model: got %h required %h", i, {result, cout, zero, set}, e);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat, rl;
        bit ch, to;
        run_op(3'b000, 16'hF0F0, 16'h3C3C, 1'b0, lat, rl, ch, to);
        tests++;
        if (to || result !== 16'h3030) begin
            fails++;
            $display("FAIL b2b_and: result=%h timeout=%0b required 3030", result, to);
        end
        // The next start lands in the DONE cycle, and a mid-RUN start with op=101 must be ignored.
        run_op(3'b001, 16'h0F00, 16'h00F0, 1'b1, lat, rl, ch, to);
        tests++;
        if (to || lat != NIB || result !== 16'h0FF0 || {cout, zero, set} !== 3'b000) begin
            fails++;
            $display("FAIL b2b_or: result=%h c/z/s=%b%b%b latency=%0d required 0ff0 000 %0d", result, cout, zero, set, lat, NIB);
        end
        tests++;
        if (ch) begin
            fails++;
            $display("FAIL b2b_hold: outputs changed during RUN, required held");
        end
        @(posedge clk); #1;
        tests++;
        if ({done, ready} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_pulse: done/ready=%b required 01", {done, ready});
        end
    endtask

    task automatic test_rst_mid_run;
        int lat, rl;
        bit ch, to, saw_done;
        run_op(3'b010, 16'h1111, 16'h2222, 1'b0, lat, rl, ch, to);
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 16'h7000; b = 16'h1000;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        tests++;
        if ({ready, done, result, cout, zero, set} !== {2'b10, W'(0), 3'b000}) begin
            fails++;
            $display("FAIL rst_abort: ready=%b done=%b result=%h c/z/s=%b%b%b required 1 0 0000 000", ready, done, result, cout, zero, set);
        end
        saw_done = 1'b0;
        repeat (NIB + 2) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL rst_no_done: done=1 after abort required 0");
        end
        // rst and start in the same cycle: the reset must win.
        @(negedge clk); rst = 1'b1; start = 1'b1; op = 3'b010; a = 16'h0001; b = 16'h0001;
        @(posedge clk); #1; rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({ready, done} !== 2'b10) begin
            fails++;
            $display("FAIL rst_priority: ready/done=%b required 10", {ready, done});
        end
        run_op(3'b010, 16'h0001, 16'h0001, 1'b0, lat, rl, ch, to);
        tests++;
        if (to || lat != NIB || result !== 16'h0002 || {cout, zero, set} !== 3'b000) begin
            fails++;
            $display("FAIL rst_recover: result=%h c/z/s=%b%b%b latency=%0d required 0002 000 %0d", result, cout, zero, set, lat, NIB);
        end
    endtask

    task automatic test_random;
        int lat, rl;
        bit ch, to;
        logic [2:0] o;
        logic [W-1:0] x, y;
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? x : W'($urandom);
            if ($urandom_range(0, 3) == 0) x = W'($urandom_range(0, 15));
            e = model(o, x, y);
            run_op(o, x, y, ($urandom_range(0, 1) == 1), lat, rl, ch, to);
            tests++;
            if (to || lat != NIB || rl != NIB || ch || {result, cout, zero, set} !== e) begin
                fails++;
                $display("FAIL rand%0d op=%b a=%h b=%h: got %h lat=%0d rl=%0d ch=%0b required %h lat=%0d", i, o, x, y, {result, cout, zero, set}, lat, rl, ch, e, NIB);
            end
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_rst_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
